// File: rtl/run_pattern_generator.sv
// Purpose: turns (bit, length) run commands into a serial bit stream on x, one bit per clk,
//          with back-to-back runs and no gap cycles.
// Ports  : clk, rst (sync, active-high); cmd_valid/cmd_bit/cmd_len with cmd_ready handshake;
//          x, x_active, run_done, busy outputs. z_pred is present only when PATGEN_ZPRED_EN
//          is defined (DET_LEN is declared only in that build).
module run_pattern_generator #(
  parameter int LEN_W    = 4,
  parameter bit IDLE_BIT = 1'b0
`ifdef PATGEN_ZPRED_EN
  ,
  parameter int DET_LEN  = 4
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic             cmd_bit,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             cmd_ready,
  output logic             x,
  output logic             x_active,
  output logic             run_done,
  output logic             busy
`ifdef PATGEN_ZPRED_EN
  ,
  output logic             z_pred
`endif
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic             run_bit, run_bit_nxt;
  logic [LEN_W-1:0] remaining, remaining_nxt;
  logic             hold_full, hold_full_nxt;
  logic             hold_bit, hold_bit_nxt;
  logic [LEN_W-1:0] hold_len, hold_len_nxt;
  logic             x_nxt;
  logic             accept;
  logic             cmd_live;
  logic             last_bit;

  assign cmd_ready = !hold_full;
  assign accept    = cmd_valid & cmd_ready;
  // Null commands are consumed by the handshake but never touch run or hold.
  assign cmd_live  = accept && (cmd_len != '0);
  assign last_bit  = (state == RUN) && (remaining == LEN_W'(1));

  assign x_active  = (state == RUN);
  assign run_done  = last_bit;
  assign busy      = x_active | hold_full;

  always_comb begin
    state_nxt     = state;
    run_bit_nxt   = run_bit;
    remaining_nxt = remaining;
    hold_full_nxt = hold_full;
    hold_bit_nxt  = hold_bit;
    hold_len_nxt  = hold_len;
    case (state)
      IDLE: begin
        if (cmd_live) begin
          state_nxt     = RUN;
          run_bit_nxt   = cmd_bit;
          remaining_nxt = cmd_len;
        end
      end
      RUN: begin
        if (last_bit) begin
          // Hand over to the next run on this edge so x never gaps.
          // cmd_ready is low whenever hold is full, so the two sources never collide.
          hold_full_nxt = 1'b0;
          if (hold_full && (hold_len != '0)) begin
            run_bit_nxt   = hold_bit;
            remaining_nxt = hold_len;
          end else if (cmd_live) begin
            run_bit_nxt   = cmd_bit;
            remaining_nxt = cmd_len;
          end else begin
            state_nxt     = IDLE;
            remaining_nxt = '0;
          end
        end else begin
          remaining_nxt = remaining - LEN_W'(1);
          if (cmd_live) begin
            hold_full_nxt = 1'b1;
            hold_bit_nxt  = cmd_bit;
            hold_len_nxt  = cmd_len;
          end
        end
      end
      default: begin
        state_nxt     = IDLE;
        remaining_nxt = '0;
      end
    endcase
    x_nxt = (state_nxt == RUN) ? run_bit_nxt : IDLE_BIT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      run_bit   <= 1'b0;
      remaining <= '0;
      hold_full <= 1'b0;
      hold_bit  <= 1'b0;
      hold_len  <= '0;
      x         <= IDLE_BIT;
    end else begin
      state     <= state_nxt;
      run_bit   <= run_bit_nxt;
      remaining <= remaining_nxt;
      hold_full <= hold_full_nxt;
      hold_bit  <= hold_bit_nxt;
      hold_len  <= hold_len_nxt;
      x         <= x_nxt;
    end
  end

`ifdef PATGEN_ZPRED_EN
  localparam int CW = $clog2(DET_LEN + 1);

  // same_cnt = length of the streak that the current x value belongs to, saturating.
  // z_pred is registered from it, so it reports the streak ending in the previous cycle.
  logic [CW-1:0] same_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      same_cnt <= '0;
      z_pred   <= 1'b0;
    end else begin
      z_pred <= (same_cnt >= CW'(DET_LEN));
      if (x_nxt == x)
        same_cnt <= (same_cnt >= CW'(DET_LEN)) ? same_cnt : same_cnt + CW'(1);
      else
        same_cnt <= CW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_run_pattern_generator.sv
module tb_run_pattern_generator;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_bit;
  logic [3:0] cmd_len;
  logic       cmd_ready;
  logic       x;
  logic       x_active;
  logic       run_done;
  logic       busy;
`ifdef PATGEN_ZPRED_EN
  logic       z_pred;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  run_pattern_generator dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_bit   (cmd_bit),
    .cmd_len   (cmd_len),
    .cmd_ready (cmd_ready),
    .x         (x),
    .x_active  (x_active),
    .run_done  (run_done),
    .busy      (busy)
`ifdef PATGEN_ZPRED_EN
    ,
    .z_pred    (z_pred)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic b, input logic [3:0] len);
    cmd_valid = 1'b1;
    cmd_bit   = b;
    cmd_len   = len;
  endtask

  logic [7:0] pat3;
  logic [7:0] done3;
`ifdef PATGEN_ZPRED_EN
  logic [8:0] zexp;
`endif

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_bit   = 1'b0;
    cmd_len   = '0;

    // 1: reset with a command offered; it must not be taken
    send(1'b1, 4'd4);
    tick();
    tick();
    chk("rst_x", x, 0);
    chk("rst_active", x_active, 0);
    chk("rst_done", run_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cmd_ready, 1);
    cmd_valid = 1'b0;
    rst       = 1'b0;
    tick();
    chk("rst_cmd_ignored", x_active, 0);

    // 2: single run (1,4)
    send(1'b1, 4'd4);
    tick();
    cmd_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk("r4_x", x, 1);
      chk("r4_active", x_active, 1);
      chk("r4_done", run_done, (i == 4) ? 1 : 0);
      tick();
    end
    chk("r4_end_x", x, 0);
    chk("r4_end_active", x_active, 0);
    chk("r4_end_done", run_done, 0);

    // 3: (1,3) followed back-to-back by (0,5) which waits in hold
    pat3  = 8'b0000_0111;   // bit i-1 = expected x in run cycle i
    done3 = 8'b1000_0100;   // run_done on cycles 3 and 8
    send(1'b1, 4'd3);
    tick();
    chk("bb_x_1", x, 1);
    chk("bb_act_1", x_active, 1);
    chk("bb_ready_1", cmd_ready, 1);
    send(1'b0, 4'd5);
    tick();
    cmd_valid = 1'b0;
    for (int i = 2; i <= 8; i++) begin
      chk("bb_x", x, pat3[i-1]);
      chk("bb_act", x_active, 1);
      chk("bb_done", run_done, done3[i-1]);
      chk("bb_ready", cmd_ready, (i == 2 || i == 3) ? 0 : 1);
      chk("bb_busy", busy, 1);
      tick();
    end
    chk("bb_end_act", x_active, 0);
    chk("bb_end_busy", busy, 0);

    // 4: null command while idle
    send(1'b1, 4'd0);
    chk("null_ready_pre", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    chk("null_act", x_active, 0);
    chk("null_done", run_done, 0);
    chk("null_ready", cmd_ready, 1);
    chk("null_busy", busy, 0);
    tick();
    chk("null_act_2", x_active, 0);

    // 5: reset on the 2nd bit of (1,6) with (0,3) held
    send(1'b1, 4'd6);
    tick();
    chk("mr_x_1", x, 1);
    send(1'b0, 4'd3);
    tick();
    cmd_valid = 1'b0;
    chk("mr_x_2", x, 1);
    chk("mr_hold_ready", cmd_ready, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_x", x, 0);
    chk("mr_act", x_active, 0);
    chk("mr_busy", busy, 0);
    chk("mr_ready", cmd_ready, 1);
    chk("mr_done", run_done, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("mr_held_dropped", x_active, 0);
    end

`ifdef PATGEN_ZPRED_EN
    // 6: predicted detector output around a (1,5) run after a long idle
    chk("zp_idle", z_pred, 1);
    send(1'b1, 4'd5);
    tick();
    cmd_valid = 1'b0;
    // cycles after 1st..5th one, then after 1st..4th idle zero
    zexp = 9'b1_0001_1000;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("zp_seq", z_pred, zexp[i]);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
